// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// Optional grant statistics counters: define ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [OP_WIDTH-1:0]   req0_op_i,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [OP_WIDTH-1:0]   req1_op_i,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,

    output logic [OP_WIDTH-1:0]   alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i,
    input  logic                  alu_carry_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [DATA_WIDTH-1:0] rsp_result_o,
    output logic                  rsp_zero_o,
    output logic                  rsp_carry_o,

    output logic                  busy_o
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [15:0]           grant_cnt0_o,
    output logic [15:0]           grant_cnt1_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   id_q;
    logic   grant0;
    logic   grant1;
    logic   accept0;
    logic   accept1;

    // A lone requester always wins; on a tie the one not served last wins.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = req0_valid_i;
            grant1 = req1_valid_i;
        end
    end

    assign accept0 = ~reset && (state == IDLE) && grant0 && req0_valid_i;
    assign accept1 = ~reset && (state == IDLE) && grant1 && req1_valid_i;

    assign req0_ready_o = accept0;
    assign req1_ready_o = accept1;

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            id_q         <= 1'b0;
            alu_op_o     <= '0;
            alu_a_o      <= '0;
            alu_b_o      <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= 1'b0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            rsp_carry_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept0 || accept1) begin
                        alu_op_o   <= accept1 ? req1_op_i : req0_op_i;
                        alu_a_o    <= accept1 ? req1_a_i  : req0_a_i;
                        alu_b_o    <= accept1 ? req1_b_i  : req0_b_i;
                        id_q       <= accept1;
                        last_grant <= accept1;
                        busy_o     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_o <= alu_result_i;
                    rsp_zero_o   <= alu_zero_i;
                    rsp_carry_o  <= alu_carry_i;
                    rsp_id_o     <= id_q;
                    rsp_valid_o  <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    // Operand registers keep their values; only the handshake leaves RESP.
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_ARBITER_STATS_EN
    // Free-running 16-bit grant counters; wrap naturally at 0xFFFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_o <= '0;
            grant_cnt1_o <= '0;
        end else begin
            if (accept0) grant_cnt0_o <= grant_cnt0_o + 16'd1;
            if (accept1) grant_cnt1_o <= grant_cnt1_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a small ALU model.
// Stats checks are compiled in when ALU_SHARE_ARBITER_STATS_EN is defined.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready;
    logic [OW-1:0] req0_op;
    logic [DW-1:0] req0_a, req0_b;
    logic          req1_valid, req1_ready;
    logic [OW-1:0] req1_op;
    logic [DW-1:0] req1_a, req1_b;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          alu_zero, alu_carry;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry;
    logic [DW-1:0] rsp_result;
    logic          busy;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [15:0]   grant_cnt0, grant_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int viol     = 0;

    int            acc_id[$];
    int            acc_cyc[$];
    int            rsp_id_q[$];
    logic [DW-1:0] rsp_res_q[$];
    logic          rsp_z_q[$];
    logic          rsp_c_q[$];

    alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .alu_op_o     (alu_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .alu_carry_i  (alu_carry),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero),
        .rsp_carry_o  (rsp_carry),
        .busy_o       (busy)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        ,
        .grant_cnt0_o (grant_cnt0),
        .grant_cnt1_o (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU: op 0 = add (carry out), op 1 = sub (borrow), else AND.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_op)
            4'd0:    {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1:    begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            default: alu_result = alu_a & alu_b;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    always @(posedge clk) cyc <= cyc + 1;

    // Log accepts and response handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
        if (req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
        if (req0_ready && req1_ready) viol++;
        if ((req0_ready || req1_ready) && busy) viol++;
        if (rsp_valid && rsp_ready) begin
            rsp_id_q.push_back(int'(rsp_id));
            rsp_res_q.push_back(rsp_result);
            rsp_z_q.push_back(rsp_zero);
            rsp_c_q.push_back(rsp_carry);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_id.delete();  acc_cyc.delete();
        rsp_id_q.delete(); rsp_res_q.delete(); rsp_z_q.delete(); rsp_c_q.delete();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        clear_logs();
        reset = 1'b0;
    endtask

    // Issue one op from a single requester and drain its response.
    task automatic do_op(input int id, input logic [OW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit got = 1'b0;
        if (id == 0) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else         begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        rsp_ready = 1'b1;
        for (int k = 0; k < 10 && !got; k++) begin
            #1;
            got = (id == 0) ? req0_ready : req1_ready;
            tick();
        end
        if (!got) check("op_accept_timeout", 0, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;

        // Reset state and single-requester add.
        tick();
        req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        tick();
        check("rdy0_in_reset", req0_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        #1;
        check("add_rdy0", req0_ready, 1);
        check("add_rdy1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("add_busy", busy, 1);
        check("add_rsp_early", rsp_valid, 0);
        check("add_alu_b", alu_b, 7);
        tick();
        check("add_rsp_valid", rsp_valid, 1);
        check("add_result", rsp_result, 12);
        check("add_id", rsp_id, 0);
        check("add_zero", rsp_zero, 0);
        check("add_carry", rsp_carry, 0);
        tick();
        check("add_rsp_clear", rsp_valid, 0);
        check("add_idle", busy, 0);

        // Tie from the first cycle after reset: requester 0 first.
        do_reset();
        req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        req1_op = 4'd1; req1_a = 32'd3; req1_b = 32'd5; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && acc_id.size() < 2; k++) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();
        if (acc_id.size() == 2 && rsp_id_q.size() == 2) begin
            check("tie_first_id", acc_id[0], 0);
            check("tie_second_id", acc_id[1], 1);
            check("tie_spacing", acc_cyc[1] - acc_cyc[0], 3);
            check("tie_res0", rsp_res_q[0], 32'd2);
            check("tie_rid1", rsp_id_q[1], 1);
            check("tie_res1", rsp_res_q[1], 32'hFFFF_FFFE);
            check("tie_carry1", rsp_c_q[1], 1);
            check("tie_zero1", rsp_z_q[1], 0);
        end else begin
            check("tie_count", acc_id.size() * 10 + rsp_id_q.size(), 22);
        end

        // Fairness under continuous contention.
        do_reset();
        req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2; req0_valid = 1'b1;
        req1_op = 4'd0; req1_a = 32'd3; req1_b = 32'd4; req1_valid = 1'b1;
        for (int k = 0; k < 40 && acc_id.size() < 6; k++) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();
        if (acc_id.size() == 6 && rsp_id_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("fair_id%0d", i), acc_id[i], i % 2);
                check($sformatf("fair_res%0d", i), rsp_res_q[i], (i % 2) ? 32'd7 : 32'd3);
                if (i > 0) check($sformatf("fair_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
            end
        end else begin
            check("fair_count", acc_id.size() * 10 + rsp_id_q.size(), 66);
        end

        // Backpressure: response held for 4 cycles.
        do_reset();
        rsp_ready = 1'b0;
        req0_op = 4'd1; req0_a = 32'd9; req0_b = 32'd9; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_op = 4'd0; req1_a = 32'd1; req1_b = 32'd2; req1_valid = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_valid%0d", k), rsp_valid, 1);
            check($sformatf("bp_result%0d", k), rsp_result, 0);
            check($sformatf("bp_zero%0d", k), rsp_zero, 1);
            check($sformatf("bp_rdy1_%0d", k), req1_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_hs_rdy1", req1_ready, 0);
        check("bp_hs_valid", rsp_valid, 1);
        tick();
        check("bp_after_valid", rsp_valid, 0);
        check("bp_after_busy", busy, 0);
        check("bp_after_rdy1", req1_ready, 1);
        req1_valid = 1'b0;
        tick();

        // Reset during EXEC drops the operation and restores tie priority.
        do_reset();
        rsp_ready = 1'b1;
        req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_alu_a", alu_a, 0);
        check("mid_alu_b", alu_b, 0);
        check("mid_busy_clr", busy, 0);
        check("mid_rsp_result", rsp_result, 0);
        reset = 1'b0;
        req0_op = 4'd0; req0_a = 32'd2; req0_b = 32'd2; req0_valid = 1'b1;
        req1_op = 4'd0; req1_a = 32'd8; req1_b = 32'd8; req1_valid = 1'b1;
        #1;
        check("mid_tie_rdy0", req0_ready, 1);
        check("mid_tie_rdy1", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();
        check("mid_rsp_count", rsp_id_q.size(), 1);

`ifdef ALU_SHARE_ARBITER_STATS_EN
        // Grant counters and wrap.
        do_reset();
        check("cnt_rst0", grant_cnt0, 0);
        check("cnt_rst1", grant_cnt1, 0);
        do_op(0, 4'd0, 32'd1, 32'd1);
        do_op(0, 4'd0, 32'd1, 32'd1);
        do_op(1, 4'd0, 32'd1, 32'd1);
        do_op(0, 4'd0, 32'd1, 32'd1);
        check("cnt0_three", grant_cnt0, 3);
        check("cnt1_one", grant_cnt1, 1);
        force dut.grant_cnt0_o = 16'hFFFF;
        #1;
        release dut.grant_cnt0_o;
        do_op(0, 4'd0, 32'd1, 32'd1);
        check("cnt0_wrap", grant_cnt0, 0);
`endif

        check("protocol_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
